// File: rtl/ram_port_arbiter_if.sv
// Request/response and RAM-side bus for ram_port_arbiter.
// req_lock exists only when ARB_LOCK_EN is defined.
interface ram_port_arbiter_if #(
  parameter int unsigned N  = 2,
  parameter int unsigned AW = 16,
  parameter int unsigned DW = 16
);
  logic [N-1:0]    req_valid;
  logic [N-1:0]    req_we;
  logic [N*AW-1:0] req_addr;
  logic [N*DW-1:0] req_wdata;
  logic [N-1:0]    req_ready;
  logic [N-1:0]    rsp_valid;
  logic [DW-1:0]   rsp_rdata;
  logic [AW-1:0]   ram_address;
  logic [DW-1:0]   ram_data;
  logic            ram_wren;
  logic [DW-1:0]   ram_q;
`ifdef ARB_LOCK_EN
  logic [N-1:0]    req_lock;
`endif

  // Requesters plus the RAM itself.
  modport master (
    output req_valid, req_we, req_addr, req_wdata, ram_q,
`ifdef ARB_LOCK_EN
    output req_lock,
`endif
    input  req_ready, rsp_valid, rsp_rdata, ram_address, ram_data, ram_wren
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata, ram_q,
`ifdef ARB_LOCK_EN
    input  req_lock,
`endif
    output req_ready, rsp_valid, rsp_rdata, ram_address, ram_data, ram_wren
  );
endinterface

// File: rtl/ram_port_arbiter.sv
// Round-robin arbiter sharing one synchronous RAM port among N requesters.
// Define ARB_LOCK_EN to add req_lock: a locked winner keeps the port for up to LOCK_MAX repeats.
module ram_port_arbiter #(
  parameter int unsigned N            = 2,
  parameter int unsigned AW           = 16,
  parameter int unsigned DW           = 16,
  parameter int unsigned READ_LATENCY = 1,
  parameter int unsigned LOCK_MAX     = 16
) (
  input logic              clock,
  input logic              reset,
  ram_port_arbiter_if.slave bus
);
  localparam int unsigned PW = (N > 1) ? $clog2(N) : 1;
  localparam int unsigned D  = READ_LATENCY + 1;

  logic [PW-1:0] r_ptr;
  logic [AW-1:0] r_addr;
  logic [DW-1:0] r_data;
  logic          r_wren;
  logic [DW-1:0] r_rdata;
  logic          r_tag_vld [D];
  logic [PW-1:0] r_tag_id  [D];

  logic [PW-1:0] w_rr_win;
  logic          w_rr_any;
  logic [PW-1:0] w_win;
  logic          w_any;
  logic          w_xfer;
  logic          w_lock_hit;
  logic [PW-1:0] w_ptr_next;
  logic [AW-1:0] w_addr;
  logic [DW-1:0] w_wdata;
  logic          w_we;

  // First valid requester at or after r_ptr, wrapping modulo N.
  always_comb begin
    logic [PW:0] v_idx;
    w_rr_win = '0;
    w_rr_any = 1'b0;
    v_idx    = '0;
    for (int k = 0; k < N; k++) begin
      v_idx = {1'b0, r_ptr} + (PW+1)'(k);
      if (v_idx >= (PW+1)'(N)) v_idx = v_idx - (PW+1)'(N);
      if (!w_rr_any && bus.req_valid[v_idx[PW-1:0]]) begin
        w_rr_any = 1'b1;
        w_rr_win = v_idx[PW-1:0];
      end
    end
  end

`ifdef ARB_LOCK_EN
  localparam int unsigned CW = $clog2(LOCK_MAX + 1);

  logic [PW-1:0] r_last;
  logic          r_last_vld;
  logic [CW-1:0] r_lock_cnt;

  assign w_lock_hit = r_last_vld && bus.req_lock[r_last] && bus.req_valid[r_last] &&
                      (r_lock_cnt < CW'(LOCK_MAX));
  assign w_win      = w_lock_hit ? r_last : w_rr_win;
  assign w_any      = w_lock_hit | w_rr_any;

  always_ff @(posedge clock) begin
    if (reset) begin
      r_last     <= '0;
      r_last_vld <= 1'b0;
      r_lock_cnt <= '0;
    end else if (w_xfer) begin
      r_last     <= w_win;
      r_last_vld <= 1'b1;
      r_lock_cnt <= w_lock_hit ? r_lock_cnt + 1'b1 : '0;
    end
  end
`else
  assign w_lock_hit = 1'b0;
  assign w_win      = w_rr_win;
  assign w_any      = w_rr_any;
`endif

  assign w_xfer        = w_any & ~reset;
  assign bus.req_ready = w_xfer ? (N'(1) << w_win) : '0;
  assign w_ptr_next    = (w_win == PW'(N - 1)) ? '0 : w_win + 1'b1;

  always_comb begin
    w_addr  = '0;
    w_wdata = '0;
    w_we    = 1'b0;
    for (int i = 0; i < N; i++) begin
      if (w_win == PW'(i)) begin
        w_addr  = bus.req_addr[i*AW +: AW];
        w_wdata = bus.req_wdata[i*DW +: DW];
        w_we    = bus.req_we[i];
      end
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      r_ptr   <= '0;
      r_addr  <= '0;
      r_data  <= '0;
      r_wren  <= 1'b0;
      r_rdata <= '0;
      for (int s = 0; s < D; s++) begin
        r_tag_vld[s] <= 1'b0;
        r_tag_id[s]  <= '0;
      end
    end else begin
      r_wren <= w_xfer & w_we;
      if (w_xfer) begin
        r_addr <= w_addr;
        r_data <= w_wdata;
        if (!w_lock_hit) r_ptr <= w_ptr_next;
      end
      // Read tags ride alongside the RAM access; the last stage lines up with ram_q.
      r_tag_vld[0] <= w_xfer & ~w_we;
      r_tag_id[0]  <= w_win;
      for (int s = 1; s < D; s++) begin
        r_tag_vld[s] <= r_tag_vld[s-1];
        r_tag_id[s]  <= r_tag_id[s-1];
      end
      if (r_tag_vld[D-1]) r_rdata <= bus.ram_q;
    end
  end

  assign bus.ram_address = r_addr;
  assign bus.ram_data    = r_data;
  assign bus.ram_wren    = r_wren;
  assign bus.rsp_valid   = r_tag_vld[D-1] ? (N'(1) << r_tag_id[D-1]) : '0;
  assign bus.rsp_rdata   = r_tag_vld[D-1] ? bus.ram_q : r_rdata;
endmodule
